// File: rtl/inst_dispatch.sv
// rtl/inst_dispatch.sv - in-order instruction queue feeding NUM_UNITS render controllers round-robin
// Optional INST_DISPATCH_PERF_EN adds saturating issue / stalled-offer counters.
module inst_dispatch #(
    parameter int INST_WIDTH = 64,
    parameter int PC_WIDTH   = 16,
    parameter int DEPTH      = 8,
    parameter int NUM_UNITS  = 4
) (
    input  logic                    clk_100mhz,
    input  logic                    rst,
    input  logic                    inst_valid_in,
    input  logic [INST_WIDTH-1:0]   inst_in,
    input  logic [PC_WIDTH-1:0]     pc_in,
    input  logic                    flush,
    input  logic [NUM_UNITS-1:0]    unit_busy,
    output logic                    stall,
    output logic [NUM_UNITS-1:0]    dispatch_valid,
    output logic [INST_WIDTH-1:0]   dispatch_inst,
    output logic [PC_WIDTH-1:0]     dispatch_pc,
    output logic [$clog2(DEPTH):0]  fifo_count
`ifdef INST_DISPATCH_PERF_EN
    ,
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_stall_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int EW = INST_WIDTH + PC_WIDTH;

    logic [EW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [UW-1:0]          rr_ptr;

    logic                   enq;
    logic                   deq;
    logic [NUM_UNITS-1:0]   eligible;
    logic                   sel_found;
    logic [UW-1:0]          sel_unit;
    logic [NUM_UNITS-1:0]   sel_onehot;
    logic [UW-1:0]          rr_next;
    logic [EW-1:0]          head;

    assign stall = (fifo_count == DEPTH[AW:0]);
    assign enq   = inst_valid_in && !stall && !flush && !rst;

    // The previous cycle's strobe doubles as the lockout mask, so busy has a cycle to rise.
    assign eligible = ~unit_busy & ~dispatch_valid;

    always_comb begin
        int unsigned idx;
        logic [UW-1:0] cand;
        idx        = 0;
        cand       = '0;
        sel_found  = 1'b0;
        sel_unit   = '0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx  = (int'(rr_ptr) + k) % NUM_UNITS;
            cand = UW'(idx);
            if (!sel_found && eligible[cand]) begin
                sel_found        = 1'b1;
                sel_unit         = cand;
                sel_onehot[cand] = 1'b1;
            end
        end
    end

    assign deq     = (fifo_count != '0) && sel_found && !flush;
    assign rr_next = (sel_unit == UW'(NUM_UNITS - 1)) ? '0 : sel_unit + 1'b1;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_100mhz) begin
        if (enq) begin
            mem[wr_ptr] <= {pc_in, inst_in};
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            rr_ptr         <= '0;
            dispatch_valid <= '0;
            dispatch_inst  <= '0;
            dispatch_pc    <= '0;
        end else if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            dispatch_valid <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr         <= rd_ptr + 1'b1;
                rr_ptr         <= rr_next;
                dispatch_valid <= sel_onehot;
                dispatch_inst  <= head[INST_WIDTH-1:0];
                dispatch_pc    <= head[EW-1:INST_WIDTH];
            end else begin
                dispatch_valid <= '0;
            end
            case ({enq, deq})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef INST_DISPATCH_PERF_EN
    // Flush leaves the counters alone; only reset clears them.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            perf_issued       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (deq && (perf_issued != '1)) begin
                perf_issued <= perf_issued + 1'b1;
            end
            if (stall && inst_valid_in && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_dispatch.sv
// tb/tb_inst_dispatch.sv - queue-based reference model plus directed scenarios for inst_dispatch
module tb_inst_dispatch;

    localparam int IW = 64;
    localparam int PW = 16;
    localparam int DEPTH = 8;
    localparam int NU = 4;

    logic           clk_100mhz = 1'b0;
    logic           rst;
    logic           inst_valid_in;
    logic [IW-1:0]  inst_in;
    logic [PW-1:0]  pc_in;
    logic           flush;
    logic [NU-1:0]  unit_busy;
    logic           stall;
    logic [NU-1:0]  dispatch_valid;
    logic [IW-1:0]  dispatch_inst;
    logic [PW-1:0]  dispatch_pc;
    logic [3:0]     fifo_count;

    inst_dispatch #(.INST_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(DEPTH), .NUM_UNITS(NU)) dut (
        .clk_100mhz     (clk_100mhz),
        .rst            (rst),
        .inst_valid_in  (inst_valid_in),
        .inst_in        (inst_in),
        .pc_in          (pc_in),
        .flush          (flush),
        .unit_busy      (unit_busy),
        .stall          (stall),
        .dispatch_valid (dispatch_valid),
        .dispatch_inst  (dispatch_inst),
        .dispatch_pc    (dispatch_pc),
        .fifo_count     (fifo_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: program-order queue, last-strobe lockout, rotating start unit.
    logic [IW-1:0] m_iq[$];
    logic [PW-1:0] m_pq[$];
    int            m_rr;
    logic [NU-1:0] m_valid;
    logic [IW-1:0] m_inst;
    logic [PW-1:0] m_pc;
    int            m_pick;
    bit            m_full;

    always @(posedge clk_100mhz) begin
        if (rst) begin
            m_iq.delete();
            m_pq.delete();
            m_rr    = 0;
            m_valid = '0;
            m_inst  = '0;
            m_pc    = '0;
        end else if (flush) begin
            m_iq.delete();
            m_pq.delete();
            m_valid = '0;
        end else begin
            m_full = (m_iq.size() == DEPTH);
            m_pick = -1;
            if (m_iq.size() > 0) begin
                for (int k = 0; k < NU; k++) begin
                    if (m_pick < 0 && !unit_busy[(m_rr + k) % NU] && !m_valid[(m_rr + k) % NU])
                        m_pick = (m_rr + k) % NU;
                end
            end
            if (m_pick >= 0) begin
                m_inst  = m_iq.pop_front();
                m_pc    = m_pq.pop_front();
                m_valid = NU'(1) << m_pick;
                m_rr    = (m_pick + 1) % NU;
            end else begin
                m_valid = '0;
            end
            if (inst_valid_in && !m_full) begin
                m_iq.push_back(inst_in);
                m_pq.push_back(pc_in);
            end
        end
    end

    logic [NU-1:0] prev_dv = '0;
    int b2b = 0;
    int n_u2 = 0;

    always @(negedge clk_100mhz) begin
        if (cmp_en) begin
            chk("stall", stall, 64'(m_iq.size() == DEPTH));
            chk("fifo_count", fifo_count, 64'(m_iq.size()));
            chk("dispatch_valid", dispatch_valid, m_valid);
            chk("dispatch_inst", dispatch_inst, m_inst);
            chk("dispatch_pc", dispatch_pc, m_pc);
            if ((dispatch_valid & prev_dv) != '0) b2b++;
            if (dispatch_valid == 4'b0100) n_u2++;
            prev_dv = dispatch_valid;
        end
    end

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inst_valid_in = 1'b0;
        flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic offer(input logic [PW-1:0] pc);
        inst_valid_in = 1'b1;
        pc_in = pc;
        inst_in = {48'hC0DE_0000_0000, pc};
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        inst_valid_in = 1'b0;
        inst_in = '0;
        pc_in = '0;
        unit_busy = '0;
        tick();
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_dv", dispatch_valid, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_stall", stall, 0);
        chk("reset_pc", dispatch_pc, 0);
        chk("reset_inst", dispatch_inst, 0);

        // single instruction, two-cycle latency
        inst_valid_in = 1'b1;
        inst_in = 64'h0000_0000_0000_00A5;
        pc_in = 16'h0010;
        tick();
        inst_valid_in = 1'b0;
        chk("single_lat1_dv", dispatch_valid, 0);
        chk("single_lat1_count", fifo_count, 1);
        tick();
        chk("single_dv", dispatch_valid, 4'b0001);
        chk("single_pc", dispatch_pc, 16'h0010);
        chk("single_inst", dispatch_inst, 64'hA5);
        chk("single_count", fifo_count, 0);
        tick();
        chk("single_strobe_once", dispatch_valid, 0);
        chk("single_hold_pc", dispatch_pc, 16'h0010);

        // three back-to-back, round robin 0,1,2
        do_reset();
        offer(16'h0101);
        tick();
        chk("b2b_e1_dv", dispatch_valid, 0);
        offer(16'h0102);
        tick();
        chk("b2b_e2_dv", dispatch_valid, 4'b0001);
        chk("b2b_e2_pc", dispatch_pc, 16'h0101);
        offer(16'h0103);
        tick();
        chk("b2b_e3_dv", dispatch_valid, 4'b0010);
        chk("b2b_e3_pc", dispatch_pc, 16'h0102);
        inst_valid_in = 1'b0;
        tick();
        chk("b2b_e4_dv", dispatch_valid, 4'b0100);
        chk("b2b_e4_pc", dispatch_pc, 16'h0103);
        chk("b2b_count", fifo_count, 0);

        // fill to full with all units busy, then release unit 2
        do_reset();
        unit_busy = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            offer(16'h0200 + 16'(i));
            tick();
        end
        chk("full_count", fifo_count, 8);
        chk("full_stall", stall, 1);
        unit_busy = 4'b1011;
        tick();
        chk("release_dv", dispatch_valid, 4'b0100);
        chk("release_pc", dispatch_pc, 16'h0200);
        chk("release_count", fifo_count, 7);
        chk("release_stall", stall, 0);
        tick();
        inst_valid_in = 1'b0;
        b2b = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("release_drained", fifo_count, 0);
        chk("release_last_pc", dispatch_pc, 16'h0208);
        chk("release_lockout", b2b, 0);

        // steady input with only unit 2 free
        do_reset();
        unit_busy = 4'b1011;
        b2b = 0;
        n_u2 = 0;
        for (int i = 0; i < 12; i++) begin
            offer(16'h0300 + 16'(i));
            tick();
        end
        inst_valid_in = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("lockout_b2b", b2b, 0);
        chk("lockout_issues", n_u2, 12);
        chk("lockout_last_pc", dispatch_pc, 16'h030B);

        // flush with five queued and a live input
        do_reset();
        unit_busy = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            offer(16'h0400 + 16'(i));
            tick();
        end
        chk("preflush_count", fifo_count, 5);
        unit_busy = 4'b0000;
        flush = 1'b1;
        offer(16'hDEAD);
        tick();
        flush = 1'b0;
        inst_valid_in = 1'b0;
        chk("flush_count", fifo_count, 0);
        chk("flush_dv", dispatch_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_no_issue", dispatch_valid, 0);
        end

        // reset mid-operation
        do_reset();
        unit_busy = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            offer(16'h0500 + 16'(i));
            tick();
        end
        inst_valid_in = 1'b0;
        unit_busy = 4'b0000;
        tick();
        chk("premid_dv", dispatch_valid, 4'b0001);
        chk("premid_count", fifo_count, 3);
        rst = 1'b1;
        offer(16'h0555);
        tick();
        rst = 1'b0;
        chk("midrst_dv", dispatch_valid, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_pc", dispatch_pc, 0);
        chk("midrst_inst", dispatch_inst, 0);
        offer(16'h0077);
        tick();
        inst_valid_in = 1'b0;
        tick();
        chk("post_rst_dv", dispatch_valid, 4'b0001);
        chk("post_rst_pc", dispatch_pc, 16'h0077);
        for (int i = 0; i < 3; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_dispatch.md
INST_DISPATCH -- requirements
Module: inst_dispatch

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 64, width of one decoded instruction word.
REQ-002 SHALL have parameter PC_WIDTH, default 16, width of the instruction address.
REQ-003 SHALL have parameter DEPTH, default 8, queue entries; power of two, >= 2.
REQ-004 SHALL have parameter NUM_UNITS, default 4, downstream render controllers; range 1..16.
REQ-005 SHALL have port clk_100mhz, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port inst_valid_in, input, 1, decoded instruction present.
REQ-008 SHALL have port inst_in, input, INST_WIDTH, decoded instruction.
REQ-009 SHALL have port pc_in, input, PC_WIDTH, address of inst_in.
REQ-010 SHALL have port flush, input, 1, discard all queued and in-flight entries.
REQ-011 SHALL have port unit_busy, input, NUM_UNITS, bit i high = unit i cannot accept.
REQ-012 SHALL have port stall, output, 1, upstream must hold; high when queue full.
REQ-013 SHALL have port dispatch_valid, output, NUM_UNITS, one-hot-or-zero issue strobe.
REQ-014 SHALL have port dispatch_inst, output, INST_WIDTH, issued instruction.
REQ-015 SHALL have port dispatch_pc, output, PC_WIDTH, issued address.
REQ-016 SHALL have port fifo_count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-017 SHALL enqueue inst_in/pc_in when inst_valid_in=1 and stall=0 and flush=0.
REQ-018 SHALL drive stall combinationally = (fifo_count == DEPTH); a same-cycle dequeue does not release stall.
REQ-019 SHALL treat a unit as eligible when unit_busy[i]=0 and i was not issued to in the previous cycle (one-cycle lockout covers busy lag).
REQ-020 SHALL, when queue non-empty and >=1 unit eligible, dequeue head and issue to first eligible unit searching from rr_ptr upward, wrapping modulo NUM_UNITS.
REQ-021 SHALL advance rr_ptr to (issued unit + 1) mod NUM_UNITS after each issue; unchanged otherwise.
REQ-022 SHALL register dispatch_valid/dispatch_inst/dispatch_pc; strobe high exactly one cycle per issue.
REQ-023 SHALL give minimum latency 2 cycles: input accepted at edge N, dispatch_valid high in cycle after edge N+1.
REQ-024 SHALL hold dispatch_inst/dispatch_pc at last issued value when dispatch_valid=0.
REQ-025 SHALL, on simultaneous enqueue and dequeue, keep fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-026 SHALL issue nothing when empty; no underflow; issue at most one instruction per cycle.
REQ-027 SHALL, on flush, set fifo_count=0, read/write pointers=0, dispatch_valid=0 next cycle, clear lockout; rr_ptr retained; input that cycle dropped.
REQ-028 SHALL preserve program order of issue across all units.

Reset
REQ-029 SHALL on rst set pointers, fifo_count, rr_ptr, lockout to 0; dispatch_valid=0; dispatch_inst, dispatch_pc=0.
REQ-030 SHALL give rst priority over flush, enqueue and issue; reset mid-operation discards all entries.

Configuration
REQ-031 SHALL, with macro INST_DISPATCH_PERF_EN defined, add outputs perf_issued (32b, count of issues) and perf_stall_cycles (32b, cycles stall=1 and inst_valid_in=1); both saturate at all-ones, cleared by rst only.
REQ-032 SHALL, without INST_DISPATCH_PERF_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-033 Single instruction 0x...A5, pc=0x0010, all units idle, rr_ptr=0 -> dispatch_valid=4'b0001, dispatch_pc=0x0010, two cycles after input.
REQ-034 Three back-to-back inputs, unit_busy=0 -> issues to units 0,1,2 in order on consecutive cycles, fifo_count returns 0.
REQ-035 unit_busy=4'b1111, 9 inputs offered -> 8 accepted, stall=1 with fifo_count=8; release unit_busy[2] -> next issue on unit 2, stall drops following cycle.
REQ-036 Queue holds 5, flush=1 while inst_valid_in=1 -> next cycle fifo_count=0, dispatch_valid=0, flushed input never issued.
REQ-037 unit_busy=4'b1011, steady input -> every issue goes to unit 2 no more often than every other cycle (lockout).
REQ-038 rst asserted with queue holding 3 and strobe active -> next cycle all outputs 0, later inputs issue from unit 0.
